// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write/flag/line bundle between the UART bridge and the TX path
interface uart_tx_fifo_if #(
  parameter int C_DATA_BITS = 8
);
  logic [C_DATA_BITS-1:0] TX_data;
  logic                   wr_uart_en;
  logic                   Enable_tx;
  logic                   Full;
  logic                   Empty;
  logic                   Busy;
  logic                   TX;

  modport master (
    output TX_data, wr_uart_en, Enable_tx,
    input  Full, Empty, Busy, TX
  );

  modport slave (
    input  TX_data, wr_uart_en, Enable_tx,
    output Full, Empty, Busy, TX
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx_fifo #(
  parameter int C_BAUDRATE    = 115_200,
  parameter int C_SYSTEM_FREQ = 50_000_000,
  parameter int C_DATA_BITS   = 8,
  parameter int C_USE_PARITY  = 0,
  parameter int C_ODD_PARITY  = 0,
  parameter int C_FIFO_DEPTH  = 16
) (
  input logic           Clk,
  input logic           Resetn,
  uart_tx_fifo_if.slave bus
);
  localparam int C_BIT_CLKS = C_SYSTEM_FREQ / C_BAUDRATE;
  localparam int CW = $clog2(C_BIT_CLKS + 1);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int BW = $clog2(C_DATA_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_n;

  logic [C_DATA_BITS-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, count_n;
  logic                   full_r, empty_r;
  logic                   push, pop;
  logic [C_DATA_BITS-1:0] head, shift, shift_n;
  logic                   par, par_n, tx_r, tx_n;
  logic [CW-1:0]          baud_cnt, baud_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic                   bit_done, can_start;

  // Full blocks the write even when a pop lands on the same edge.
  assign push      = bus.wr_uart_en && !full_r;
  assign head      = mem[rd_ptr];
  assign bit_done  = (baud_cnt == CW'(C_BIT_CLKS - 1));
  assign can_start = !empty_r && bus.Enable_tx;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= bus.TX_data;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      full_r  <= (count_n == (AW+1)'(C_FIFO_DEPTH));
      empty_r <= (count_n == '0);
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx_r     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      par      <= par_n;
      tx_r     <= tx_n;
    end
  end

  // Baud counter restarts whenever a bit ends, so every state entry sees it at zero.
  always_comb begin
    state_n = state;
    baud_n  = bit_done ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par;
    tx_n    = tx_r;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (^head) ^ 1'(C_ODD_PARITY);
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_cnt == BW'(C_DATA_BITS - 1)) begin
            if (C_USE_PARITY != 0) begin
              tx_n    = par;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            shift_n = shift >> 1;
            tx_n    = shift[1];
            bit_n   = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          tx_n    = 1'b1;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (can_start) begin
            pop     = 1'b1;
            shift_n = head;
            par_n   = (^head) ^ 1'(C_ODD_PARITY);
            tx_n    = 1'b0;
            state_n = S_START;
          end else begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.TX    = tx_r;
  assign bus.Full  = full_r;
  assign bus.Empty = empty_r;
  assign bus.Busy  = (state != S_IDLE);
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit half of the UART. It buffers bytes written by the UART bridge in a synchronous FIFO and serialises them onto the TX pin as 8N1 frames by default: start bit, data bits LSB first, optional parity bit, one stop bit. It mirrors the receive path's handshake: write-enable in, a Full flag out, and an enable gate for the line.

Parameters:
C_BAUDRATE, 115_200, line bit rate.
C_SYSTEM_FREQ, 50_000_000, Clk frequency in Hz. Bit period C_BIT_CLKS = C_SYSTEM_FREQ / C_BAUDRATE, integer division (434 at defaults).
C_DATA_BITS, 8, data bits per frame (5..8).
C_USE_PARITY, 0, 1 inserts a parity bit after the data bits.
C_ODD_PARITY, 0, 1 selects odd parity, 0 selects even. Ignored when C_USE_PARITY=0.
C_FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Resetn  input  1  asynchronous, active-low reset.
TX_data  input  C_DATA_BITS  byte to enqueue.
wr_uart_en  input  1  one-cycle write strobe; TX_data is sampled on the same edge.
Enable_tx  input  1  1 allows new frames to start.
Full  output  1  FIFO holds C_FIFO_DEPTH entries.
Empty  output  1  FIFO holds 0 entries.
Busy  output  1  a frame is on the line (FSM not IDLE).
TX  output  1  serial line, idle high, registered.

Behaviour:
- Reset (async assert, sync release): TX=1, Full=0, Empty=1, Busy=0. FIFO pointers, count, bit counter, baud counter and FSM all clear; FSM goes to IDLE. Reset asserted mid-frame aborts the frame immediately: TX returns to 1 and FIFO contents are discarded.
- FIFO write: a write is accepted when wr_uart_en=1 and Full=0 on the edge. A write while Full=1 is dropped silently, even if a pop occurs on the same edge. No overflow flag.
- FIFO count: the count updates on the accepting edge; Full and Empty are registered from the count.
- Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Pointers wrap modulo C_FIFO_DEPTH.
- Baud counter: counts 0..C_BIT_CLKS-1 and is cleared on every state entry. A bit ends on the edge where the counter equals C_BIT_CLKS-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when Empty=0 and Enable_tx=1, pop the head into the shift register, compute parity, go to START and drive TX=0 on that edge. Latency from a write into an empty FIFO with the FSM in IDLE is 2 edges: the write edge, then the pop edge where TX falls.
- START: after one bit period, go to DATA and drive TX = shift[0].
- DATA: after each bit period, shift right and drive the next bit. After C_DATA_BITS bits, go to PARITY if C_USE_PARITY=1, otherwise go to STOP with TX=1.
- PARITY: TX = (XOR of data bits) XOR C_ODD_PARITY. After one bit period, go to STOP with TX=1.
- STOP: TX=1 for one bit period. At its final edge, if Empty=0 and Enable_tx=1, pop and enter START directly with TX=0, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Frame length: (C_DATA_BITS + 2 + C_USE_PARITY) × C_BIT_CLKS clocks. At defaults this is 4340.
- Enable_tx deasserted mid-frame: the current frame completes, then the FSM holds in IDLE.
- Busy: 1 in every state except IDLE.

Test Plan:
- Reset: pulse Resetn low for 2 cycles with no writes -> TX=1, Full=0, Empty=1, Busy=0 throughout.
- Single byte (defaults): write 0x55 while idle -> TX falls 1 edge after the write edge. Sampling TX at offset 217 + 434·k gives 0,1,0,1,0,1,0,1,0,1. Busy falls 4340 clocks after TX fell.
- Back-to-back: write 0x7E, 0xFE, 0x81 on 3 consecutive cycles -> three contiguous frames totalling 13020 clocks, no idle cycle between stop and start. Decoded bytes match in order.
- Full/drop: with Enable_tx=0, write 18 bytes 0x00..0x11 -> Full=1 after the 16th write, and 0x10 and 0x11 are dropped. Raising Enable_tx sends exactly 0x00..0x0F, after which Empty=1.
- Parity: with C_USE_PARITY=1 and C_ODD_PARITY=1, write 0x03 -> parity bit 1. Write 0x07 -> parity bit 0. Frame length is 4774 clocks.
- Reset mid-frame: assert Resetn low during data bit 4 of 0xFF -> TX=1 with no clock edge needed. After release, writing 0xA5 produces one clean frame 0,1,0,1,0,0,1,0,1,1.
